// File: rtl/div_quot_bcd_pkg.sv
// Shared types and sizing helpers for the divider quotient-to-BCD stage.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // ceil(n * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
  function automatic int unsigned bcd_digits(input int unsigned n);
    return (n * 30103 + 99999) / 100000;
  endfunction

  localparam int unsigned DEF_N = 32;
  localparam int unsigned DEF_D = bcd_digits(DEF_N);

endpackage

// File: rtl/div_quot_bcd_add3.sv
// Double-dabble per-digit adjust: digits of 5 or more get 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/div_quot_bcd.sv
// Sequential binary-to-BCD converter for the divider quotient, one bit per clock,
// with remainder and divide-by-zero flag carried alongside the result.
module div_quot_bcd
  import div_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 8,
  parameter int D = bcd_digits(N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_quot,
  input  logic [M-1:0]             in_rem,
  input  logic                     in_dz,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*D-1:0]           out_bcd,
  output logic [$clog2(D+1)-1:0]   out_ndig,
  output logic [M-1:0]             out_rem,
  output logic                     out_dz
);

  // state | meaning
  // IDLE  | waiting for a quotient; in_ready high
  // SHIFT | double-dabble iterations, one quotient bit per clock
  // DONE  | result held on the outputs until out_ready

  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int NDW = $clog2(D+1);

  state_e          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [4*D-1:0]  bcd_q,   bcd_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [M-1:0]    rem_q,   rem_d;
  logic            dz_q,    dz_d;
  logic [4*D-1:0]  bcd_adj;
  logic [NDW-1:0]  ndig;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_quot;
          rem_d   = in_rem;
          dz_d    = in_dz;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // adjusted digits and the quotient shift as one word so the MSB enters bcd bit 0
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ndig = NDW'(1);
    for (int i = 0; i < D; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        ndig = NDW'(i + 1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign out_ndig  = ndig;
  assign out_rem   = rem_q;
  assign out_dz    = dz_q;

endmodule

// File: tb/tb_div_quot_bcd.sv
// Scoreboard bench for div_quot_bcd: driver queues expected results, a monitor
// compares them whenever the DUT hands a result over.
module tb_div_quot_bcd;

  localparam int N = 32;
  localparam int M = 8;
  localparam int D = 10;

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  ndig;
    logic [7:0]  rem;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_quot;
  logic [7:0]  in_rem;
  logic        in_dz;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_bcd;
  logic [3:0]  out_ndig;
  logic [7:0]  out_rem;
  logic        out_dz;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_quot_bcd #(.N(N), .M(M), .D(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_quot   (in_quot),
    .in_rem    (in_rem),
    .in_dz     (in_dz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ndig  (out_ndig),
    .out_rem   (out_rem),
    .out_dz    (out_dz)
  );

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t dec_exp(input logic [31:0] q, input logic [7:0] r, input logic dz);
    exp_t  e;
    string s;
    s = $sformatf("%0d", q);
    e.bcd = '0;
    for (int i = 0; i < s.len(); i++) begin
      e.bcd[4*i +: 4] = 4'(s[s.len()-1-i] - 8'd48);
    end
    e.ndig = 4'(s.len());
    e.rem  = r;
    e.dz   = dz;
    return e;
  endfunction

  // Monitor: a result is consumed at the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1'b0, {24'd0, out_bcd}, 64'd0);
      end else begin
        exp_t e;
        bit   bad;
        e = exp_q.pop_front();
        chk("out_bcd",  out_bcd  == e.bcd,  {24'd0, out_bcd},  {24'd0, e.bcd});
        chk("out_ndig", out_ndig == e.ndig, {60'd0, out_ndig}, {60'd0, e.ndig});
        chk("out_rem",  out_rem  == e.rem,  {56'd0, out_rem},  {56'd0, e.rem});
        chk("out_dz",   out_dz   == e.dz,   {63'd0, out_dz},   {63'd0, e.dz});
        bad = 1'b0;
        for (int i = 0; i < D; i++) begin
          if (out_bcd[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        chk("digit_le_9", !bad, {24'd0, out_bcd}, 64'd0);
      end
    end
  end

  // Present one operand, wait (bounded) for acceptance; returns just after the accept edge.
  task automatic send(input logic [31:0] q, input logic [7:0] r, input logic dz,
                      input exp_t e, input bit push);
    int t;
    in_quot  = q;
    in_rem   = r;
    in_dz    = dz;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1'b0, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input logic [31:0] q, input logic [7:0] r, input logic dz,
                     input logic [39:0] bcd, input logic [3:0] nd);
    exp_t e;
    e.bcd = bcd; e.ndig = nd; e.rem = r; e.dz = dz;
    send(q, r, dz, e, 1'b1);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   lat_ok;
    logic [31:0] q;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_quot   = '0;
    in_rem    = '0;
    in_dz     = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  in_ready  == 1'b1, {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", out_valid == 1'b0, {63'd0, out_valid}, 64'd0);
    chk("rst_out_bcd",   out_bcd   == 40'd0, {24'd0, out_bcd},  64'd0);
    chk("rst_out_ndig",  out_ndig  == 4'd1, {60'd0, out_ndig},  64'd1);
    chk("rst_out_rem",   out_rem   == 8'd0, {56'd0, out_rem},   64'd0);
    chk("rst_out_dz",    out_dz    == 1'b0, {63'd0, out_dz},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero, with an exact latency check: valid appears only after the N-th edge past accept
    e.bcd = 40'd0; e.ndig = 4'd1; e.rem = 8'd0; e.dz = 1'b0;
    send(32'd0, 8'd0, 1'b0, e, 1'b1);
    lat_ok = 1'b1;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #1;
      if (out_valid != (i == N)) lat_ok = 1'b0;
    end
    chk("latency_N", lat_ok, {63'd0, out_valid}, 64'd1);
    drain();

    vec(32'hFFFF_FFFF, 8'h07, 1'b0, 40'h42_9496_7295, 4'd10);
    vec(32'd12345,     8'h00, 1'b1, 40'h00_0001_2345, 4'd5);
    vec(32'd1,         8'h5A, 1'b0, 40'h1,            4'd1);
    vec(32'd9,         8'h00, 1'b0, 40'h9,            4'd1);
    vec(32'd10,        8'h01, 1'b0, 40'h10,           4'd2);
    vec(32'd1_000_000_000, 8'hFF, 1'b1, 40'h10_0000_0000, 4'd10);

    // Consumer stall: outputs held and no accept while out_ready is low
    out_ready = 1'b0;
    e.bcd = 40'h00_0004_0960; e.ndig = 4'd5; e.rem = 8'h33; e.dz = 1'b0;
    send(32'd40960, 8'h33, 1'b0, e, 1'b1);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("stall_valid_seen", out_valid == 1'b1, {63'd0, out_valid}, 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid == 1'b1, {63'd0, out_valid}, 64'd1);
      chk("stall_ready", in_ready == 1'b0,  {63'd0, in_ready},  64'd0);
      chk("stall_bcd",   out_bcd == 40'h00_0004_0960, {24'd0, out_bcd}, 64'h40960);
      chk("stall_rem",   out_rem == 8'h33, {56'd0, out_rem}, 64'h33);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready",  in_ready == 1'b1,  {63'd0, in_ready},  64'd1);
    chk("release_out_valid", out_valid == 1'b0, {63'd0, out_valid}, 64'd0);
    drain();

    // New operand held on in_valid during SHIFT must be ignored
    e.bcd = 40'h00_0000_4321; e.ndig = 4'd4; e.rem = 8'h11; e.dz = 1'b0;
    send(32'd4321, 8'h11, 1'b0, e, 1'b1);
    in_quot  = 32'd8888;
    in_rem   = 8'h22;
    in_dz    = 1'b1;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    for (int k = 0; k < 100; k++) begin
      q = $urandom();
      if (k % 4 == 1) q = q >> $urandom_range(31, 1);
      e = dec_exp(q, 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      send(q, e.rem, e.dz, e, 1'b1);
      drain();
    end

    // Reset in the middle of SHIFT, counter at 10
    e.bcd = 40'd0; e.ndig = 4'd1; e.rem = 8'd0; e.dz = 1'b0;
    send(32'd7777777, 8'h44, 1'b1, e, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid == 1'b0, {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready",  in_ready == 1'b1,  {63'd0, in_ready},  64'd1);
    chk("abort_out_bcd",   out_bcd == 40'd0,  {24'd0, out_bcd},   64'd0);
    chk("abort_out_dz",    out_dz == 1'b0,    {63'd0, out_dz},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vec(32'd99, 8'h00, 1'b0, 40'h99, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_quot_bcd.md
Name: div_quot_bcd

Overview:
- Downstream stage of the N/M parallel divider: accepts one quotient/remainder result per valid/ready handshake.
- Converts the N-bit binary quotient to packed BCD with a sequential double-dabble engine (one bit per clock).
- Passes the remainder and the divide-by-zero flag through alongside the BCD result, for display/UART formatting logic downstream.

Parameters:
- N, 32, quotient width (same as divider dividend width).
- M, 8, remainder width (same as divider divisor width).
- D, 10, BCD digit count; must satisfy D >= ceil(N*log10(2)) (10 for N=32).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  quotient/remainder presented.
- in_ready  out  1  block idle, can accept.
- in_quot  in  N  binary quotient.
- in_rem  in  M  remainder.
- in_dz  in  1  divisor was zero.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_bcd  out  4*D  packed BCD; digit 0 is in bits [3:0].
- out_ndig  out  clog2(D+1)  significant digits, 1..D.
- out_rem  out  M  registered in_rem.
- out_dz  out  1  registered in_dz.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_ndig=1, out_rem=0, out_dz=0, bit counter=0.
- FSM states IDLE, SHIFT, DONE. in_ready=(state==IDLE). out_valid=(state==DONE).
- IDLE:
  - on an edge with in_valid&in_ready: capture in_quot into the shift register; capture in_rem and in_dz.
  - clear the BCD register and counter; go to SHIFT.
- SHIFT, each edge:
  - add 3 to every BCD digit >= 5;
  - shift {bcd,shreg} left by 1 so the quotient MSB enters bcd bit 0;
  - counter++.
  - After the N-th iteration (counter==N-1 on that edge), go to DONE.
- Latency: accept at edge k -> out_valid high after edge k+N. Outputs are stable throughout DONE.
- DONE:
  - out_ready high at an edge -> go to IDLE; in_ready rises after that edge.
  - No same-cycle re-accept. Throughput is one result per N+2 cycles minimum.
  - out_ready low holds all outputs indefinitely.
- in_valid while busy (SHIFT/DONE) is ignored. No capture occurs and there is no error; the upstream holds per the handshake.
- out_ndig = index of the highest nonzero digit + 1; it is 1 when the value is 0. It is combinational from the BCD register and only meaningful while out_valid=1.
- When in_dz=1, the quotient is still converted as given; out_dz flags it. Interpreting the quotient is the consumer's job.
- Digit width: per-digit adjust uses 4-bit compare/add. No digit may exceed 9 at DONE; a digit >9 is a design error and the bench asserts on it.
- Reset mid-SHIFT or mid-DONE aborts the conversion immediately and leaves no partial result visible.

Decomposition:
- Shared package div_pkg:
  - FSM state enum (IDLE/SHIFT/DONE);
  - localparam for the digit count derived from N;
  - BCD digit typedef (logic [3:0]).
- One sub-module is natural: bcd_add3, a combinational per-digit adjust (x>=5 ? x+3 : x), instantiated D times by generate.

Test Plan:
- in_quot=0, in_rem=0 -> after 32 cycles out_bcd=0, out_ndig=1.
- in_quot=32'hFFFF_FFFF, in_rem=8'h07 -> out_bcd=40'h42_9496_7295, out_ndig=10, out_rem=7.
- in_quot=12345, in_dz=1 -> out_bcd=40'h00_0001_2345, out_ndig=5, out_dz=1.
- out_ready low for 5 cycles after out_valid -> outputs constant, in_ready=0. Then raise out_ready -> in_ready=1 on the next cycle.
- in_valid held with new data during SHIFT -> ignored; the result matches the first operand. 100 random operands are compared against $sformatf("%0d") of the quotient.
- rst_n pulsed low at SHIFT counter=10 -> out_valid=0 and in_ready=1 immediately. The next conversion (in_quot=99) -> out_bcd=40'h99, out_ndig=2.
